// File: rtl/key_event_gen_pkg.sv
// Shared types and constants for the direction-key command generator.
// The state enum and the direction indices are used by the RTL and by the bench.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2,
        RPT  = 2'd3
    } state_t;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

endpackage

// File: rtl/key_event_gen_if.sv
// Valid/ready command channel from the key event generator to the game controller.
// The generator drives the master modport and the consumer drives the slave modport.
interface key_event_gen_if #(
    parameter int DW = 2
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_dir;
    logic          cmd_repeat;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_repeat,
        output cmd_ready
    );
endinterface

// File: rtl/key_prio_enc.sv
// Combinational priority encoder: reports whether any key is pressed and
// the index of the lowest-numbered pressed key.
module key_prio_enc #(
    parameter int N_KEYS = 4,
    parameter int IW     = $clog2(N_KEYS)
) (
    input  logic [N_KEYS-1:0] i_pressed,
    output logic              o_any,
    output logic [IW-1:0]     o_idx
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        // Scan downward so the lowest pressed index is the last one written.
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (i_pressed[i]) begin
                o_any = 1'b1;
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Turns debounced active-low direction keys into press and auto-repeat move
// commands on a valid/ready channel, paced by the 1 ms tick strobe.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int N_KEYS    = 4,
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 150,
    parameter int CW        = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1ms,
    input  logic [N_KEYS-1:0] key_n,
    key_event_gen_if.master   cmd
);

    localparam int DW = $clog2(N_KEYS);

    logic [N_KEYS-1:0] r_key_q;
    state_t            r_state;
    state_t            w_state_nx;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nx;
    logic [DW-1:0]     r_dir;
    logic [DW-1:0]     w_dir_nx;
    logic              r_repeat;
    logic              w_repeat_nx;

    logic [N_KEYS-1:0] w_pressed;
    logic              w_any;
    logic [DW-1:0]     w_idx;
    logic              w_held;
    logic [CW-1:0]     w_limit;

    assign w_pressed = ~r_key_q;
    assign w_held    = w_pressed[r_dir];
    assign w_limit   = (r_state == RPT) ? CW'(REPEAT_MS - 1) : CW'(HOLD_MS - 1);

    key_prio_enc #(
        .N_KEYS (N_KEYS),
        .IW     (DW)
    ) u_prio_enc (
        .i_pressed (w_pressed),
        .o_any     (w_any),
        .o_idx     (w_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q  <= '1;
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_dir    <= '0;
            r_repeat <= 1'b0;
        end else begin
            r_key_q  <= key_n;
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_dir    <= w_dir_nx;
            r_repeat <= w_repeat_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_dir_nx    = r_dir;
        w_repeat_nx = r_repeat;

        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_dir_nx    = w_idx;
                    w_repeat_nx = 1'b0;
                    w_state_nx  = PEND;
                end
            end
            PEND: begin
                // A release never withdraws an offered command; it only
                // decides where we go once the command has been taken.
                if (cmd.cmd_ready) begin
                    w_cnt_nx = '0;
                    if (!w_held) begin
                        w_state_nx = IDLE;
                    end else if (r_repeat) begin
                        w_state_nx = RPT;
                    end else begin
                        w_state_nx = HOLD;
                    end
                end
            end
            HOLD, RPT: begin
                // Release is checked first so it beats a coincident limit tick.
                if (!w_held) begin
                    w_cnt_nx   = '0;
                    w_state_nx = IDLE;
                end else if (tick_1ms) begin
                    if (r_cnt == w_limit) begin
                        w_repeat_nx = 1'b1;
                        w_state_nx  = PEND;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign cmd.cmd_valid  = (r_state == PEND);
    assign cmd.cmd_dir    = r_dir;
    assign cmd.cmd_repeat = r_repeat;

endmodule

// File: tb/tb_key_event_gen.sv
// Self-checking bench for key_event_gen: a cycle-exact vector table with ticks
// suppressed, then hand-written tick-paced sequences for repeat and reset cases.
module tb_key_event_gen;
    import key_event_pkg::*;

    localparam int N_KEYS = 4;
    localparam int HOLD   = 3;
    localparam int RPTMS  = 2;
    localparam int CW     = 10;
    localparam int DW     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick_1ms;
    logic [N_KEYS-1:0] key_n;

    key_event_gen_if #(.DW(DW)) bus ();

    key_event_gen #(
        .N_KEYS    (N_KEYS),
        .HOLD_MS   (HOLD),
        .REPEAT_MS (RPTMS),
        .CW        (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1ms (tick_1ms),
        .key_n    (key_n),
        .cmd      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dir;
        logic          rep;
        int            ticks;
    } xfer_t;

    typedef struct {
        logic [N_KEYS-1:0] key_n;
        logic              ready;
        logic              exp_valid;
        logic [DW-1:0]     exp_dir;
        logic              exp_rep;
    } vec_t;

    xfer_t log_q[$];
    vec_t  vecs[15];
    int    n_checks = 0;
    int    n_errors = 0;
    int    ticks_total = 0;
    int    tick_phase = 0;
    bit    tick_auto = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: log any transfer on this edge, then settle 1 ns past it.
    task automatic step();
        xfer_t x;
        if (tick_1ms) ticks_total++;
        if (!rst && bus.cmd_valid && bus.cmd_ready) begin
            x.dir   = bus.cmd_dir;
            x.rep   = bus.cmd_repeat;
            x.ticks = ticks_total;
            log_q.push_back(x);
        end
        @(posedge clk);
        #1;
        if (tick_auto) begin
            tick_1ms   = (tick_phase == 3);
            tick_phase = (tick_phase + 1) % 4;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_xfer(input int max_cycles, output bit ok);
        int start;
        start = log_q.size();
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (log_q.size() > start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base;
        int  snap;
        int  n;
        bit  ok;
        bit  stable;

        // key_n, ready, exp_valid, exp_dir, exp_rep (ticks suppressed)
        vecs[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{4'b1011, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[2]  = '{4'b1011, 1'b0, 1'b1, 2'(DIR_LEFT), 1'b0};
        vecs[3]  = '{4'b1011, 1'b0, 1'b1, 2'(DIR_LEFT), 1'b0};
        vecs[4]  = '{4'b1011, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[5]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{4'b0110, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{4'b0110, 1'b0, 1'b1, 2'(DIR_UP), 1'b0};
        vecs[9]  = '{4'b0111, 1'b0, 1'b1, 2'(DIR_UP), 1'b0};
        vecs[10] = '{4'b0111, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{4'b0111, 1'b0, 1'b1, 2'(DIR_RIGHT), 1'b0};
        vecs[12] = '{4'b0111, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};

        rst           = 1'b1;
        tick_1ms      = 1'b0;
        key_n         = 4'b1111;
        bus.cmd_ready = 1'b0;
        steps(3);
        check("reset_valid", 32'(bus.cmd_valid), 0);
        check("reset_dir", 32'(bus.cmd_dir), 0);
        check("reset_repeat", 32'(bus.cmd_repeat), 0);
        rst = 1'b0;

        // Cycle-exact table: latency, stall, priority, re-press after release.
        for (int v = 0; v < 15; v++) begin
            key_n         = vecs[v].key_n;
            bus.cmd_ready = vecs[v].ready;
            step();
            check($sformatf("vec%0d_valid", v), 32'(bus.cmd_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_dir", v), 32'(bus.cmd_dir), 32'(vecs[v].exp_dir));
                check($sformatf("vec%0d_rep", v), 32'(bus.cmd_repeat), 32'(vecs[v].exp_rep));
            end
        end

        // Tap key 2 for two ticks: one command, no repeat.
        tick_auto     = 1'b1;
        bus.cmd_ready = 1'b1;
        base          = log_q.size();
        key_n         = 4'b1011;
        step();
        check("tap_valid_edge1", 32'(bus.cmd_valid), 0);
        step();
        check("tap_valid_edge2", 32'(bus.cmd_valid), 1);
        steps(6);
        key_n = 4'b1111;
        steps(20);
        check("tap_count", 32'(log_q.size() - base), 1);
        if (log_q.size() > base) begin
            check("tap_dir", 32'(log_q[base].dir), 32'(DIR_LEFT));
            check("tap_rep", 32'(log_q[base].rep), 0);
        end

        // Hold key 1 for 12 ticks: press, repeat after 3 ticks, then every 2.
        base  = log_q.size();
        key_n = 4'b1101;
        steps(48);
        key_n = 4'b1111;
        steps(2);
        snap = log_q.size();
        steps(30);
        check("hold_quiet_after_release", 32'(log_q.size()), 32'(snap));
        n = snap - base;
        check("hold_enough_cmds", 32'(n >= 5), 1);
        for (int i = base; i < snap; i++) begin
            check($sformatf("hold%0d_dir", i - base), 32'(log_q[i].dir), 32'(DIR_DOWN));
            check($sformatf("hold%0d_rep", i - base), 32'(log_q[i].rep), 32'(i != base));
            if (i > base) begin
                check($sformatf("hold%0d_gap", i - base),
                      32'(log_q[i].ticks - log_q[i-1].ticks),
                      (i == base + 1) ? 32'(HOLD) : 32'(RPTMS));
            end
        end

        // Backpressure: release while pending, 20 stalled cycles.
        bus.cmd_ready = 1'b0;
        key_n         = 4'b1110;
        ok            = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            ok = bus.cmd_valid;
        end
        check("bp_valid_seen", 32'(ok), 1);
        key_n  = 4'b1111;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!(bus.cmd_valid === 1'b1 && bus.cmd_dir === 2'(DIR_UP) && bus.cmd_repeat === 1'b0))
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 1);
        base          = log_q.size();
        bus.cmd_ready = 1'b1;
        steps(30);
        check("bp_one_xfer", 32'(log_q.size() - base), 1);
        if (log_q.size() > base) begin
            check("bp_dir", 32'(log_q[base].dir), 32'(DIR_UP));
            check("bp_rep", 32'(log_q[base].rep), 0);
        end
        check("bp_idle_valid", 32'(bus.cmd_valid), 0);

        // Release lands on the same edge as the HOLD limit tick.
        tick_auto = 1'b0;
        tick_1ms  = 1'b0;
        key_n     = 4'b1011;
        wait_xfer(10, ok);
        check("rl_first_xfer", 32'(ok), 1);
        tick_1ms = 1'b1; step();
        tick_1ms = 1'b0; step();
        tick_1ms = 1'b1; step();
        tick_1ms = 1'b0;
        key_n    = 4'b1111;
        step();
        tick_1ms = 1'b1;
        step();
        tick_1ms = 1'b0;
        check("rl_valid_after_limit", 32'(bus.cmd_valid), 0);
        snap   = log_q.size();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.cmd_valid !== 1'b0) stable = 1'b0;
        end
        check("rl_no_repeat", 32'(stable), 1);
        check("rl_no_xfer", 32'(log_q.size()), 32'(snap));

        // Reset while in RPT with the key held.
        tick_auto = 1'b1;
        key_n     = 4'b0111;
        ok        = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (log_q.size() > 0 && log_q[$].rep === 1'b1 && log_q[$].dir === 2'(DIR_RIGHT))
                ok = 1'b1;
        end
        check("rst_reached_rpt", 32'(ok), 1);
        rst = 1'b1;
        step();
        check("rst_valid_low_a", 32'(bus.cmd_valid), 0);
        steps(2);
        check("rst_valid_low_b", 32'(bus.cmd_valid), 0);
        rst = 1'b0;
        step();
        check("rst_valid_edge1", 32'(bus.cmd_valid), 0);
        step();
        check("rst_valid_edge2", 32'(bus.cmd_valid), 1);
        check("rst_dir", 32'(bus.cmd_dir), 32'(DIR_RIGHT));
        check("rst_rep", 32'(bus.cmd_repeat), 0);
        key_n = 4'b1111;
        steps(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Converts the debounced, active-low direction buttons into discrete move commands for the Sokoban game logic. A new press produces one command. Holding a key produces auto-repeat commands after a hold delay. Commands are delivered over a valid/ready handshake, so the game FSM consumes moves at its own pace. The block sits between the per-button debouncers and the game controller, and paces itself from the system 1 ms tick strobe.

## Interface
Parameters:
- N_KEYS, 4: number of debounced key inputs. Index maps to direction.
- HOLD_MS, 500: ticks from acceptance of the first command to the first repeat. Legal range is 1 to 2^CW-1.
- REPEAT_MS, 150: ticks between accepted repeat commands. Legal range is 1 to 2^CW-1.
- CW, 10: tick counter width.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: system clock. All state changes occur on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- tick_1ms, in, 1: one-clk-wide strobe, once per ms. It is an enable, not a clock.
- key_n, in, N_KEYS: debounced key levels. 0 means pressed.
- cmd_valid, out, 1: a command is offered.
- cmd_ready, in, 1: the consumer accepts the command. A transfer occurs on a clk edge where valid and ready are both 1.
- cmd_dir, out, $clog2(N_KEYS): index of the key.
- cmd_repeat, out, 1: 0 for the initial press, 1 for an auto-repeat.

## Operation
- key_n is registered once into key_q. key_q resets to all 1s, meaning released. pressed = ~key_q.
- Priority: when several keys are pressed at once, the lowest index wins. Only one key is latched at a time.
- The FSM has four states: IDLE, PEND, HOLD and RPT. Reset puts it in IDLE with cnt=0 and cmd_valid=0. cmd_dir and cmd_repeat reset to 0.
- IDLE: if any key is pressed, latch dir = lowest pressed index, set cmd_repeat=0 and go to PEND. Otherwise stay in IDLE.
- PEND: cmd_valid=1, and dir and repeat are held stable.
  - On transfer, clear cnt.
  - If the latched key is released (sampled at the transfer edge), go to IDLE.
  - Otherwise, go to RPT if cmd_repeat=1, else go to HOLD.
  - A release while in PEND never withdraws the command. cmd_valid stays high until the transfer.
- HOLD: cnt increments on each tick. When a tick arrives with cnt==HOLD_MS-1, set cmd_repeat=1 and go to PEND. A release of the latched key returns to IDLE.
- RPT: same as HOLD, but the limit is REPEAT_MS-1.
- Other keys pressed while a key is latched are ignored. After release returns the FSM to IDLE, a key that is still held is treated as a new press (cmd_repeat=0).
- cnt does not run in PEND or IDLE. Consumer backpressure therefore stretches the repeat period and never queues or drops repeats.
- A release and a limit tick on the same edge: the release wins, the FSM goes to IDLE and no repeat is issued.
- Reset mid-operation returns the FSM to IDLE immediately and discards any pending command. A key held across reset yields a fresh non-repeat command after rst falls.

## Timing
- Press latency: key_n falls before edge t. key_q updates at t, the FSM enters PEND at t+1, so cmd_valid=1 after edge t+1.
- After reset deassertion with a key held: cmd_valid rises after the 2nd edge.
- cmd_valid drops in the cycle after the transfer edge. Back-to-back commands are impossible. The minimum spacing between commands is 2 clk plus the tick intervals.
- Repeat spacing in ticks: exactly HOLD_MS or REPEAT_MS tick strobes after the transfer edge. Wall-time jitter is up to 1 ms due to tick phase.
- Release latency: a release is seen 1 clk after key_n rises. The FSM reaches IDLE on the following edge.

## Structure
- Package key_event_pkg holds:
  - the state enum (IDLE, PEND, HOLD, RPT);
  - the direction constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
- Sub-module key_prio_enc: combinational lowest-index priority encoder. Inputs: pressed vector. Outputs: any, idx.
- The top level contains the input register, the FSM, cnt, and the output registers.

## Test plan
All scenarios use HOLD_MS=3, REPEAT_MS=2, a tick every 4 clk, and cmd_ready=1 unless stated.
- Tap key 2 (low for 2 ticks, then release): exactly one command with dir=2, repeat=0, cmd_valid rising 2 edges after the press, and no repeats.
- Hold key 1 for 12 ticks: the first command has repeat=0. A repeat=1 command is accepted 3 ticks later, then every 2 ticks. No commands follow the release.
- Press keys 3 and 0 together: dir=0. Then release key 0 while key 3 is held: a new command with dir=3, repeat=0.
- cmd_ready=0 for 20 clk while the key is released in PEND: cmd_valid, dir and repeat stay stable. After ready, exactly one transfer occurs, then IDLE and no repeat.
- Release on the same edge as the limit tick in HOLD: no repeat is issued and the FSM returns to IDLE.
- Assert rst while in RPT with the key held: cmd_valid=0 during reset. After rst deasserts, the next command has repeat=0 and cmd_valid rises on the 2nd edge.
